// File: rtl/mul_accumulator_if.sv
// Handshake bundle between the multiplier stream, the accumulator and the
// result consumer. The master side drives the job request, product stream
// and ready. The slave side (the accumulator) returns busy, the result and
// its flags.
interface mul_accumulator_if #(
    parameter int IN_WIDTH  = 16,
    parameter int ACC_WIDTH = 32,
    parameter int CNT_WIDTH = 8
);
    logic                 i_start;
    logic [CNT_WIDTH-1:0] i_len;
    logic                 i_valid;
    logic [IN_WIDTH-1:0]  i_product;
    logic                 i_ready;
    logic                 o_busy;
    logic                 o_valid;
    logic [ACC_WIDTH-1:0] o_acc;
    logic                 o_overflow;

    modport master (
        output i_start, i_len, i_valid, i_product, i_ready,
        input  o_busy, o_valid, o_acc, o_overflow
    );

    modport slave (
        input  i_start, i_len, i_valid, i_product, i_ready,
        output o_busy, o_valid, o_acc, o_overflow
    );
endinterface

// File: rtl/mul_accumulator.sv
// Dot-product accumulator that sits behind the 8x8 multiplier core.
// It sums i_len unsigned products into a result and holds that result on a
// valid/ready handshake until the consumer accepts it.
// Optional build macro MUL_ACC_SATURATE_EN: the accumulator clamps to
// all-ones on carry-out instead of wrapping. o_overflow behaves the same in
// both builds.
module mul_accumulator #(
    parameter int IN_WIDTH  = 16,
    parameter int ACC_WIDTH = 32,
    parameter int CNT_WIDTH = 8
) (
    input  logic               clk,
    input  logic               reset_n,
    mul_accumulator_if.slave   io_bus
);
    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ACCUM = 2'd1,
        S_HOLD  = 2'd2
    } state_t;

    localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);

    state_t               r_state;
    logic [ACC_WIDTH-1:0] r_acc;
    logic [ACC_WIDTH-1:0] r_out_acc;
    logic [CNT_WIDTH-1:0] r_cnt;
    logic [CNT_WIDTH-1:0] r_len;
    logic                 r_valid;
    logic                 r_overflow;
    logic                 r_busy;

    logic [ACC_WIDTH:0]   w_sum;
    logic                 w_carry;
    logic [ACC_WIDTH-1:0] w_next_acc;
    logic                 w_last;

    // The sum is one bit wider than the accumulator; its top bit is the carry.
    assign w_sum   = {1'b0, r_acc} + {{(ACC_WIDTH + 1 - IN_WIDTH){1'b0}}, io_bus.i_product};
    assign w_carry = w_sum[ACC_WIDTH];

`ifdef MUL_ACC_SATURATE_EN
    // Once saturated, any later non-zero product carries again and adding
    // zero leaves all-ones, so clamping on carry alone keeps it pinned.
    assign w_next_acc = w_carry ? {ACC_WIDTH{1'b1}} : w_sum[ACC_WIDTH-1:0];
`else
    assign w_next_acc = w_sum[ACC_WIDTH-1:0];
`endif

    // Only reached in ACCUM, where r_len is non-zero, so r_len-1 never wraps.
    assign w_last = (r_cnt == (r_len - CNT_ONE));

    // Job control FSM with all outputs registered.
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values, regardless of statement order.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state    <= S_IDLE;
            r_acc      <= '0;
            r_out_acc  <= '0;
            r_cnt      <= '0;
            r_len      <= '0;
            r_valid    <= 1'b0;
            r_overflow <= 1'b0;
            r_busy     <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    // A product arriving with the start pulse is not part of the job.
                    if (io_bus.i_start) begin
                        r_overflow <= 1'b0;
                        r_busy     <= 1'b1;
                        if (io_bus.i_len != '0) begin
                            r_len   <= io_bus.i_len;
                            r_acc   <= '0;
                            r_cnt   <= '0;
                            r_state <= S_ACCUM;
                        end else begin
                            r_out_acc <= '0;
                            r_valid   <= 1'b1;
                            r_state   <= S_HOLD;
                        end
                    end
                end
                S_ACCUM: begin
                    if (io_bus.i_valid) begin
                        r_acc      <= w_next_acc;
                        r_cnt      <= r_cnt + CNT_ONE;
                        r_overflow <= r_overflow | w_carry;
                        if (w_last) begin
                            r_out_acc <= w_next_acc;
                            r_valid   <= 1'b1;
                            r_state   <= S_HOLD;
                        end
                    end
                end
                S_HOLD: begin
                    if (r_valid && io_bus.i_ready) begin
                        r_valid <= 1'b0;
                        r_busy  <= 1'b0;
                        r_state <= S_IDLE;
                    end
                end
                default: begin
                    r_valid <= 1'b0;
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign io_bus.o_busy     = r_busy;
    assign io_bus.o_valid    = r_valid;
    assign io_bus.o_acc      = r_out_acc;
    assign io_bus.o_overflow = r_overflow;
endmodule

// File: tb/tb_mul_accumulator.sv
// Self-checking bench for mul_accumulator. Two instances receive identical
// stimulus: a 32-bit accumulator (dut_a) and a 16-bit one (dut_b) that
// exercises carry-out. A job-level model predicts each result. A compare
// process checks every presented result against the model, and directed
// literal checks pin latency, reset and the boundary cases.
module tb_mul_accumulator;
    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        start = 1'b0;
    logic [7:0]  len = '0;
    logic        vld = 1'b0;
    logic [15:0] prod = '0;
    logic        rdy = 1'b0;

    always #5 clk = ~clk;

    mul_accumulator_if #(.IN_WIDTH(16), .ACC_WIDTH(32), .CNT_WIDTH(8)) bus_a ();
    mul_accumulator_if #(.IN_WIDTH(16), .ACC_WIDTH(16), .CNT_WIDTH(8)) bus_b ();

    assign bus_a.i_start   = start;
    assign bus_a.i_len     = len;
    assign bus_a.i_valid   = vld;
    assign bus_a.i_product = prod;
    assign bus_a.i_ready   = rdy;
    assign bus_b.i_start   = start;
    assign bus_b.i_len     = len;
    assign bus_b.i_valid   = vld;
    assign bus_b.i_product = prod;
    assign bus_b.i_ready   = rdy;

    mul_accumulator #(.IN_WIDTH(16), .ACC_WIDTH(32), .CNT_WIDTH(8)) dut_a (
        .clk     (clk),
        .reset_n (reset_n),
        .io_bus  (bus_a)
    );

    mul_accumulator #(.IN_WIDTH(16), .ACC_WIDTH(16), .CNT_WIDTH(8)) dut_b (
        .clk     (clk),
        .reset_n (reset_n),
        .io_bus  (bus_b)
    );

    typedef struct {
        longint acc32;
        longint acc16;
        bit     ovf32;
        bit     ovf16;
    } exp_t;

    exp_t        exp_q[$];
    int          n_tests = 0;
    int          n_fail = 0;
    logic [15:0] p_list[0:15];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, req, $time);
        end
    endtask

    // Fold one product into a running sum of the given width.
    function automatic void add_one(input longint p, input longint max, inout longint s, inout bit ovf);
        s = s + p;
        if (s > max) begin
            ovf = 1'b1;
`ifdef MUL_ACC_SATURATE_EN
            s = max;
`else
            s = s - (max + 1);
`endif
        end
    endfunction

    // Expected result of a job over the first n entries of p_list.
    function automatic void model_push(input int n);
        exp_t e;
        e.acc32 = 0; e.acc16 = 0; e.ovf32 = 1'b0; e.ovf16 = 1'b0;
        for (int i = 0; i < n; i++) begin
            add_one(longint'(p_list[i]), 64'hFFFF_FFFF, e.acc32, e.ovf32);
            add_one(longint'(p_list[i]), 64'hFFFF, e.acc16, e.ovf16);
        end
        exp_q.push_back(e);
    endfunction

    // Compare every presented result against the model; retire on handshake.
    always @(negedge clk) begin
        if (reset_n && (bus_a.o_valid || bus_b.o_valid)) begin
            if (exp_q.size() == 0) begin
                check("unexpected_valid", 64'(bus_a.o_valid), 64'd0);
            end else begin
                check("cmp_valid_a", 64'(bus_a.o_valid), 64'd1);
                check("cmp_valid_b", 64'(bus_b.o_valid), 64'd1);
                check("cmp_acc_a", 64'(bus_a.o_acc), 64'(exp_q[0].acc32));
                check("cmp_acc_b", 64'(bus_b.o_acc), 64'(exp_q[0].acc16));
                check("cmp_ovf_a", 64'(bus_a.o_overflow), 64'(exp_q[0].ovf32));
                check("cmp_ovf_b", 64'(bus_b.o_overflow), 64'(exp_q[0].ovf16));
                if (bus_a.o_valid && rdy) void'(exp_q.pop_front());
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Start a job of n products from p_list with gap idle cycles before each.
    // A product is offered alongside the start pulse and must be ignored.
    // With mid_start, a second start is pulsed with the first product.
    task automatic launch(input int n, input int gap, input bit mid_start);
        model_push(n);
        start = 1'b1; len = 8'(n); vld = 1'b1; prod = 16'h00AA;
        step();
        start = 1'b0; vld = 1'b0;
        for (int i = 0; i < n; i++) begin
            for (int g = 0; g < gap; g++) step();
            vld = 1'b1; prod = p_list[i];
            if (mid_start && i == 0) begin
                start = 1'b1; len = 8'd3;
            end
            if (i == n - 1) check("valid_before_last", 64'(bus_a.o_valid), 64'd0);
            step();
            vld = 1'b0; start = 1'b0;
        end
        check("valid_latency", 64'(bus_a.o_valid), 64'd1);
        check("busy_in_hold", 64'(bus_a.o_busy), 64'd1);
    endtask

    // Hold the result for hold cycles (optionally poking HOLD with products
    // and starts), then handshake. With poke, a start also accompanies the
    // handshake cycle and must be ignored.
    task automatic complete(input int hold, input bit poke);
        logic [31:0] held;
        held = bus_a.o_acc;
        rdy = 1'b0;
        for (int i = 0; i < hold; i++) begin
            if (poke) begin
                vld = 1'b1; prod = 16'h1234; start = 1'b1; len = 8'd2;
            end
            step();
            check("hold_valid", 64'(bus_a.o_valid), 64'd1);
            check("hold_acc", 64'(bus_a.o_acc), 64'(held));
        end
        vld = 1'b0; rdy = 1'b1; start = poke;
        step();
        start = 1'b0;
        check("valid_drop", 64'(bus_a.o_valid), 64'd0);
        check("busy_drop", 64'(bus_a.o_busy), 64'd0);
        step();
        check("idle_after_hs", 64'(bus_a.o_busy), 64'd0);
    endtask

    initial begin
        // Reset
        repeat (3) step();
        reset_n = 1'b1;
        step();
        check("rst_valid", 64'(bus_a.o_valid), 64'd0);
        check("rst_acc", 64'(bus_a.o_acc), 64'd0);
        check("rst_busy", 64'(bus_a.o_busy), 64'd0);
        check("rst_ovf", 64'(bus_a.o_overflow), 64'd0);

        // Basic job, consecutive products, consumer always ready
        p_list[0] = 16'd10; p_list[1] = 16'd20; p_list[2] = 16'd30; p_list[3] = 16'd40;
        rdy = 1'b1;
        launch(4, 0, 1'b0);
        check("basic_acc", 64'(bus_a.o_acc), 64'd100);
        check("basic_ovf", 64'(bus_a.o_overflow), 64'd0);
        complete(0, 1'b0);

        // Carry out of the 16-bit instance
        p_list[0] = 16'hFFFF; p_list[1] = 16'h0002;
        launch(2, 0, 1'b0);
        check("model_pin_ovf", 64'(exp_q[0].ovf16), 64'd1);
        check("ovf_b_flag", 64'(bus_b.o_overflow), 64'd1);
`ifdef MUL_ACC_SATURATE_EN
        check("ovf_b_acc", 64'(bus_b.o_acc), 64'hFFFF);
`else
        check("ovf_b_acc", 64'(bus_b.o_acc), 64'h0001);
`endif
        check("ovf_a_acc", 64'(bus_a.o_acc), 64'h10001);
        check("ovf_a_flag", 64'(bus_a.o_overflow), 64'd0);
        complete(0, 1'b0);
        check("ovf_sticky_idle", 64'(bus_b.o_overflow), 64'd1);

        // Zero-length job: result next cycle, overflow cleared
        launch(0, 0, 1'b0);
        check("zero_acc", 64'(bus_a.o_acc), 64'd0);
        check("zero_ovf_b", 64'(bus_b.o_overflow), 64'd0);
        complete(0, 1'b0);

        // Start pulsed during ACCUM is ignored
        p_list[0] = 16'd5; p_list[1] = 16'd7;
        launch(2, 0, 1'b1);
        check("midstart_acc", 64'(bus_a.o_acc), 64'd12);
        complete(0, 1'b0);

        // Gaps between products, backpressure, pokes during HOLD
        p_list[0] = 16'hFE01; p_list[1] = 16'hFE01; p_list[2] = 16'hFE01;
        rdy = 1'b0;
        launch(3, 2, 1'b0);
        check("gap_acc", 64'(bus_a.o_acc), 64'h2FA03);
        complete(5, 1'b1);

        // Reset in the middle of a 4-product job
        rdy = 1'b1;
        start = 1'b1; len = 8'd4;
        step();
        start = 1'b0; vld = 1'b1; prod = 16'd10;
        step();
        prod = 16'd20;
        step();
        vld = 1'b0;
        check("pre_rst_busy", 64'(bus_a.o_busy), 64'd1);
        #2 reset_n = 1'b0;
        #1;
        check("midrst_busy", 64'(bus_a.o_busy), 64'd0);
        check("midrst_valid", 64'(bus_a.o_valid), 64'd0);
        check("midrst_acc_a", 64'(bus_a.o_acc), 64'd0);
        check("midrst_acc_b", 64'(bus_b.o_acc), 64'd0);
        check("midrst_ovf_b", 64'(bus_b.o_overflow), 64'd0);
        step();
        step();
        reset_n = 1'b1;
        step();
        check("postrst_valid", 64'(bus_a.o_valid), 64'd0);
        p_list[0] = 16'd9;
        launch(1, 0, 1'b0);
        check("postrst_acc", 64'(bus_a.o_acc), 64'd9);
        check("postrst_ovf", 64'(bus_a.o_overflow), 64'd0);
        complete(0, 1'b0);

        check("queue_drained", 64'(exp_q.size()), 64'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
